// File: rtl/spi_slave_drive.sv
// -----------------------------------------------------------------------------
// spi_slave_drive
//   SPI responder, fixed mode 3 (CPOL=1, CPHA=1), MSB first. SCLK, CS_N and
//   MOSI are oversampled in the sys_clk domain through 2-flop synchronizers.
//   MISO is launched on SCLK falling edges and MOSI is sampled on rising edges.
//   Several back-to-back words may be transferred per CS_N assertion.
//
//   Optional feature macro: SPI_SLV_OVR_EN
//     defined   : rx_ovr pulses for one cycle, together with the rx_data update,
//                 when a word completes while rx_valid=1 and rx_ready=0.
//     undefined : rx_ovr is tied 0 (rx_data is still overwritten).
//
// Ports
//   sys_clk, sys_rst  : system clock, synchronous active-high reset
//   tx_data, tx_load  : write next TX word into the one-deep TX buffer
//   tx_ready          : TX buffer empty
//   rx_data, rx_valid : last received word / unconsumed word present
//   rx_ready          : consumer accepts rx_data
//   rx_ovr            : overrun pulse (see macro above)
//   busy              : frame active
//   SCLK, CS_N, MOSI  : SPI inputs from the host (SCLK idles high)
//   MISO              : SPI output, high-Z while not busy
//
// Handshake: rx_data is transferred on every cycle where rx_valid && rx_ready
// are both high at the clock edge; rx_valid then drops unless a new word
// completes in that same cycle. tx_load is accepted only while tx_ready=1
// (or in the cycle the buffer is being consumed).
//
// Timing: SCLK high and low phases must each last at least 4 sys_clk cycles.
// -----------------------------------------------------------------------------
module spi_slave_drive #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_ovr,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  CS_N,
  input  logic                  MOSI,
  output logic                  MISO
);

  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // synchronizers and edge-detect copies
  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;
  // fill[1] is set once the synchronizer pipe carries real pin values
  logic [1:0] fill;
  logic       armed;

  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  tx_full;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [CW-1:0]         bit_cnt;
  // set by a rising edge; a falling edge only advances MISO after the
  // current bit has been sampled by the host
  logic                  sampled;

  logic sclk_rise, sclk_fall, cs_fall;
  logic active;
  logic frame_start, word_start, bit_shift, bit_rise, bit_fall, rx_done;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_d  <= 1'b1;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      fill    <= 2'b00;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= CS_N;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      fill    <= {fill[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_fall   = ~cs_s2 & cs_d;

  // The reset value of the CS_N synchronizer is 1, so arming waits until the
  // pipe holds the real pin; a CS_N already low at reset release never arms.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      armed <= 1'b0;
    end else if (fill[1] && cs_s2) begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (armed && cs_fall) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s2) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // SCLK edges count only while the frame is active and CS_N still low
  assign active     = (state == ACTIVE) && !cs_s2;
  assign bit_rise   = active && sclk_rise;
  assign bit_fall   = active && sclk_fall;
  assign rx_done    = bit_rise && (bit_cnt == LAST_BIT);
  assign word_start = frame_start || (bit_fall && sampled && (bit_cnt == '0));
  assign bit_shift  = bit_fall && sampled && (bit_cnt != '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_buf   <= '0;
      tx_full  <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      sampled  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (frame_start) begin
        bit_cnt <= '0;
        sampled <= 1'b0;
      end

      if (word_start) begin
        tx_shift <= tx_full ? tx_buf : '0;
      end else if (bit_shift) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (bit_fall) begin
        sampled <= 1'b0;
      end

      if (bit_rise) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s2};
        sampled  <= 1'b1;
        bit_cnt  <= rx_done ? '0 : bit_cnt + CW'(1);
      end

      // a completing word wins over a simultaneous consumer accept
      if (rx_done) begin
        rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s2};
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // consumption first, then a same-cycle load refills the buffer
      if (tx_load && (!tx_full || word_start)) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (word_start) begin
        tx_full <= 1'b0;
      end
    end
  end

`ifdef SPI_SLV_OVR_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_ovr <= 1'b0;
    end else begin
      rx_ovr <= rx_done && rx_valid && !rx_ready;
    end
  end
`else
  assign rx_ovr = 1'b0;
`endif

  assign tx_ready = !tx_full;
  assign busy     = (state == ACTIVE);
  assign MISO     = busy ? tx_shift[DATA_WIDTH-1] : 1'bz;

endmodule

// File: tb/tb_spi_slave_drive.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_drive
//   Bench for spi_slave_drive (DATA_WIDTH=8). A host task plays the SPI master
//   in mode 3; a transaction-level model tracks the TX buffer and the words the
//   host sends. Expected RX words go into exp_q and a monitor process compares
//   them whenever the DUT hands a word over (rx_valid && rx_ready).
// -----------------------------------------------------------------------------
module tb_spi_slave_drive;

  localparam int DW = 8;

  logic          sys_clk;
  logic          sys_rst;
  logic [DW-1:0] tx_data;
  logic          tx_load;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_ovr;
  logic          busy;
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  wire           miso_w;

  spi_slave_drive #(.DATA_WIDTH(DW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_ovr   (rx_ovr),
    .busy     (busy),
    .SCLK     (sclk),
    .CS_N     (cs_n),
    .MOSI     (mosi),
    .MISO     (miso_w)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int ovr_seen = 0;
  int m_ovr    = 0;
  bit hold     = 1'b0;

  // transaction-level TX buffer model
  bit            m_full = 1'b0;
  logic [DW-1:0] m_buf  = '0;

  // per-frame host plan
  logic [DW-1:0] fw[3];
  bit            ld_en[3];
  logic [DW-1:0] ld_val[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  function automatic logic [DW-1:0] mdl_consume();
    logic [DW-1:0] v;
    v      = m_full ? m_buf : '0;
    m_full = 1'b0;
    return v;
  endfunction

  function automatic void rx_push(input logic [DW-1:0] w);
    if (hold && exp_q.size() > 0) begin
      exp_q[exp_q.size()-1] = w;
      m_ovr++;
    end else begin
      exp_q.push_back(w);
    end
  endfunction

  // ---------------- monitor ----------------
  always begin
    logic [DW-1:0] e;
    @(negedge sys_clk);
    #1;
    if (!sys_rst) begin
      if (rx_ovr) ovr_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got word 0x%0h expected none at %0t", rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rx_word", rx_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [DW-1:0] v);
    check("tx_ready_pre_load", tx_ready, !m_full);
    tx_data = v;
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = v;
    end
  endtask

  // abort_bits > 0: CS_N rises after that many bits of the first word
  task automatic host_frame(input int nw, input int hp, input int abort_bits);
    logic [DW-1:0] got;
    logic [DW-1:0] exp_tx;
    int bits;
    bits   = 0;
    cs_n   = 1'b0;
    exp_tx = mdl_consume();
    wait_cyc(hp);
    check("busy_in_frame", busy, 1);
    check("tx_ready_after_start", tx_ready, !m_full);
    for (int w = 0; w < nw; w++) begin
      got = '0;
      for (int b = 0; b < DW; b++) begin
        sclk = 1'b0;
        mosi = fw[w][DW-1-b];
        if (w > 0 && b == 0) exp_tx = mdl_consume();
        wait_cyc(hp);
        got[DW-1-b] = miso_w;
        sclk = 1'b1;
        bits++;
        if (b == DW-1) rx_push(fw[w]);
        wait_cyc(hp);
        if (abort_bits > 0 && bits == abort_bits) break;
        if (b == 3 && ld_en[w]) do_load(ld_val[w]);
      end
      if (abort_bits > 0 && bits == abort_bits) break;
      check("miso_word", got, exp_tx);
    end
    cs_n = 1'b1;
    wait_cyc(hp);
    check("busy_after_frame", busy, 0);
    wait_cyc(hp);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 3; i++) begin
      fw[i]     = '0;
      ld_en[i]  = 1'b0;
      ld_val[i] = '0;
    end
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] exp_ovr;
    sys_rst  = 1'b1;
    tx_data  = '0;
    tx_load  = 1'b0;
    rx_ready = 1'b1;
    sclk     = 1'b1;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    clear_plan();
    wait_cyc(4);
    sys_rst = 1'b0;
    wait_cyc(4);

    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_ovr", rx_ovr, 0);
    check("rst_busy", busy, 0);

    // single word, loaded TX buffer
    clear_plan();
    do_load(8'hA5);
    fw[0] = 8'h3C;
    host_frame(1, 4, 0);
    check("rx_data_3c", rx_data, 8'h3C);

    // empty TX buffer shifts zeros
    clear_plan();
    fw[0] = 8'hFF;
    host_frame(1, 4, 0);
    check("rx_data_ff", rx_data, 8'hFF);

    // two words, second TX word loaded during word 1
    clear_plan();
    do_load(8'h12);
    fw[0] = 8'h81;
    fw[1] = 8'h7E;
    ld_en[0]  = 1'b1;
    ld_val[0] = 8'h34;
    host_frame(2, 5, 0);
    check("rx_data_7e", rx_data, 8'h7E);

    // overrun: consumer stalled across two words
    clear_plan();
    hold     = 1'b1;
    rx_ready = 1'b0;
    fw[0] = 8'h11;
    fw[1] = 8'h22;
    host_frame(2, 4, 0);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data", rx_data, 8'h22);
`ifdef SPI_SLV_OVR_EN
    exp_ovr = 32'(m_ovr);
`else
    exp_ovr = 32'd0;
`endif
    check("ovr_pulses", ovr_seen, exp_ovr);
    rx_ready = 1'b1;
    hold     = 1'b0;
    wait_cyc(4);
    check("ovr_drained", rx_valid, 0);

    // aborted word, then a full frame; the consumed TX word is lost
    clear_plan();
    do_load(8'h99);
    fw[0] = 8'hF0;
    host_frame(1, 4, 5);
    check("abort_no_valid", rx_valid, 0);
    clear_plan();
    fw[0] = 8'h0F;
    host_frame(1, 4, 0);
    check("rx_data_0f", rx_data, 8'h0F);

    // reset pulsed mid-frame
    clear_plan();
    do_load(8'h66);
    cs_n = 1'b0;
    wait_cyc(4);
    for (int b = 0; b < 3; b++) begin
      sclk = 1'b0; mosi = 1'b1; wait_cyc(4);
      sclk = 1'b1; wait_cyc(4);
    end
    sys_rst = 1'b1;
    wait_cyc(2);
    sys_rst = 1'b0;
    m_full  = 1'b0;
    wait_cyc(3);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    for (int b = 0; b < DW; b++) begin
      sclk = 1'b0; mosi = 1'b1; wait_cyc(4);
      sclk = 1'b1; wait_cyc(4);
    end
    check("disarmed_busy", busy, 0);
    check("disarmed_rx_valid", rx_valid, 0);
    cs_n = 1'b1;
    wait_cyc(8);
    clear_plan();
    do_load(8'hC3);
    fw[0] = 8'h5A;
    host_frame(1, 4, 0);
    check("rx_data_5a", rx_data, 8'h5A);

    // randomized frames
    for (int f = 0; f < 24; f++) begin
      int nw;
      clear_plan();
      nw = $urandom_range(1, 3);
      for (int w = 0; w < 3; w++) begin
        fw[w]     = DW'($urandom);
        ld_en[w]  = ($urandom_range(0, 2) != 0);
        ld_val[w] = DW'($urandom);
      end
      if ($urandom_range(0, 1) == 1) do_load(DW'($urandom));
      if ($urandom_range(0, 3) == 0) do_load(DW'($urandom));
      host_frame(nw, $urandom_range(4, 7), 0);
    end

    wait_cyc(10);
    check("exp_q_empty", exp_q.size(), 0);
`ifdef SPI_SLV_OVR_EN
    exp_ovr = 32'(m_ovr);
`else
    exp_ovr = 32'd0;
`endif
    check("ovr_total", ovr_seen, exp_ovr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
